bus_sequencer: RTL

BUS_SEQUENCER -- requirements
Module: bus_sequencer

---
 rtl/bus_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bus_sequencer.sv
// Register-file bus sequencer: decodes MOVE/LOADI/READ/SWAP commands into
// one-hot output/write enable sequences on a shared OR-bus.
module bus_sequencer #(
  parameter int unsigned width = 32,
  parameter int unsigned NREG  = 8,
  parameter int unsigned IDXW  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [IDXW-1:0]   cmd_src,
  input  logic [IDXW-1:0]   cmd_dst,
  input  logic [width-1:0]  cmd_imm,
  output logic [NREG-1:0]   reg_oe,
  output logic [NREG-1:0]   reg_we,
  input  logic [width-1:0]  bus_in,
  output logic [width-1:0]  wbus,
  output logic              rd_valid,
  output logic [width-1:0]  rd_data,
  output logic              busy
);

  localparam logic [1:0] OpMove  = 2'b00;
  localparam logic [1:0] OpLoadi = 2'b01;
  localparam logic [1:0] OpRead  = 2'b10;
  localparam logic [1:0] OpSwap  = 2'b11;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRdA  = 3'd1;
  localparam logic [2:0] StRdB  = 3'd2;
  localparam logic [2:0] StWrA  = 3'd3;
  localparam logic [2:0] StWrB  = 3'd4;
  localparam logic [2:0] StResp = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [IDXW-1:0]  src_q, src_d;
  logic [IDXW-1:0]  dst_q, dst_d;
  logic [width-1:0] hold_a_q, hold_a_d;
  logic [width-1:0] hold_b_q, hold_b_d;
  logic [width-1:0] rd_data_q, rd_data_d;
  logic             accept;

  assign accept = (state_q == StIdle) && cmd_valid;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src_d     = src_q;
    dst_d     = dst_q;
    hold_a_d  = hold_a_q;
    hold_b_d  = hold_b_q;
    rd_data_d = rd_data_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d  = cmd_op;
          src_d = cmd_src;
          dst_d = cmd_dst;
          if (cmd_op == OpLoadi) begin
            hold_a_d = cmd_imm;
            state_d  = StWrA;
          end else begin
            state_d  = StRdA;
          end
        end
      end
      StRdA: begin
        hold_a_d = bus_in;
        case (op_q)
          OpMove:  state_d = StWrA;
          OpSwap:  state_d = StRdB;
          OpRead: begin
            state_d   = StResp;
            rd_data_d = bus_in;
          end
          default: state_d = StIdle;
        endcase
      end
      StRdB: begin
        hold_b_d = bus_in;
        state_d  = StWrA;
      end
      StWrA:   state_d = (op_q == OpSwap) ? StWrB : StIdle;
      StWrB:   state_d = StIdle;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Reset has priority, so no command is accepted at a reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= OpMove;
      src_q     <= '0;
      dst_q     <= '0;
      hold_a_q  <= '0;
      hold_b_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      hold_a_q  <= hold_a_d;
      hold_b_q  <= hold_b_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Enables depend only on registered state and latched indices.
  always_comb begin
    reg_oe = '0;
    reg_we = '0;
    case (state_q)
      StRdA:   reg_oe[src_q] = 1'b1;
      StRdB:   reg_oe[dst_q] = 1'b1;
      StWrA:   reg_we[dst_q] = 1'b1;
      StWrB:   reg_we[src_q] = 1'b1;
      default: ;
    endcase
  end

  assign wbus      = (state_q == StWrB) ? hold_b_q : hold_a_q;
  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rd_valid  = (state_q == StResp);
  assign rd_data   = rd_data_q;

endmodule
